// File: rtl/poly_eval_horner.sv
// Horner-rule polynomial evaluator on one multiply-accumulate datapath.
// Operands enter a_N first, x last, one per Go press/release.
module poly_eval_horner #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Overflow,
  output logic             Busy
);

  localparam int FW = 2 * WIDTH + 1;
  localparam logic [4:0] IDX_TOP = 5'(DEGREE + 1);
  localparam logic [3:0] S_TOP   = 4'(DEGREE - 1);

  typedef enum logic [1:0] {
    LOAD,
    LOAD_WAIT,
    COMPUTE,
    RELEASE_WAIT
  } state_t;

  state_t           state_q;
  logic [4:0]       idx_q;
  logic [3:0]       s_q;
  logic [WIDTH-1:0] coef_q [0:DEGREE];
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic             valid_q;
  logic             ovf_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_sel;
  logic [FW-1:0]    mac_full;
  logic             mac_ovf;

  // Select a_s for the current step and form the full-precision MAC.
  always_comb begin
    a_sel = '0;
    for (int k = 0; k <= DEGREE; k++) begin
      if (s_q == 4'(k)) a_sel = coef_q[k];
    end
    mac_full = FW'(acc_q) * FW'(x_q) + FW'(a_sel);
    mac_ovf  = |mac_full[FW-1:WIDTH];
  end

  // Operand capture, handshake sequencing and Horner iteration.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= LOAD;
      idx_q   <= IDX_TOP;
      s_q     <= '0;
      for (int k = 0; k <= DEGREE; k++) coef_q[k] <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (Go) begin
            for (int k = 0; k <= DEGREE; k++) begin
              if (idx_q == 5'(k + 1)) coef_q[k] <= DataIn;
            end
            if (idx_q == 5'd0) x_q <= DataIn;
            if (idx_q == IDX_TOP) begin
              valid_q <= 1'b0;
              ovf_q   <= 1'b0;
            end
            state_q <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (!Go) begin
            if (idx_q != 5'd0) begin
              idx_q   <= idx_q - 5'd1;
              state_q <= LOAD;
            end else begin
              acc_q   <= coef_q[DEGREE];
              s_q     <= S_TOP;
              busy_q  <= 1'b1;
              state_q <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc_q <= mac_full[WIDTH-1:0];
          s_q   <= s_q - 4'd1;
          if (mac_ovf) ovf_q <= 1'b1;
          if (s_q == 4'd0) begin
            res_q   <= mac_full[WIDTH-1:0];
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= IDX_TOP;
            state_q <= Go ? RELEASE_WAIT : LOAD;
          end
        end
        RELEASE_WAIT: begin
          if (!Go) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign DataResult  = res_q;
  assign ResultValid = valid_q;
  assign Overflow    = ovf_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_poly_eval_horner.sv
// Bench for poly_eval_horner: DEGREE=2 and DEGREE=3 instances,
// reference Horner model feeding a result scoreboard.
module tb_poly_eval_horner;

  logic       clk = 1'b0;
  logic       rstn;
  logic       go2, go3;
  logic [7:0] din2, din3;
  logic [7:0] res2, res3;
  logic       rv2, rv3, ovf2, ovf3, busy2, busy3;

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] sb2[$];
  logic [8:0] sb3[$];

  int  bc2 = 0, bc3 = 0;
  logic rv2_p = 1'b0, rv3_p = 1'b0;

  always #5 clk = ~clk;

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u_dut2 (
    .Clock(clk), .Resetn(rstn), .Go(go2), .DataIn(din2),
    .DataResult(res2), .ResultValid(rv2),
    .Overflow(ovf2), .Busy(busy2)
  );

  poly_eval_horner #(.WIDTH(8), .DEGREE(3)) u_dut3 (
    .Clock(clk), .Resetn(rstn), .Go(go3), .DataIn(din3),
    .DataResult(res3), .ResultValid(rv3),
    .Overflow(ovf3), .Busy(busy3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, p(x) mod 256}; c[0] is a_N, c[n+1] is x.
  function automatic logic [8:0] model(input int n, input int c[5]);
    int acc, t, x;
    logic ov;
    x   = c[n+1];
    acc = c[0];
    ov  = 1'b0;
    for (int k = 1; k <= n; k++) begin
      t = acc * x + c[k];
      if (t > 255) ov = 1'b1;
      acc = t % 256;
    end
    return {ov, 8'(acc)};
  endfunction

  // Scoreboard side: compare on each ResultValid rising edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rstn) begin
      bc2 = 0;
      bc3 = 0;
    end else begin
      if (busy2) bc2++;
      if (busy3) bc3++;
      if (rv2 && !rv2_p) begin
        check("sb2_pending", 32'(sb2.size() > 0), 1);
        if (sb2.size() > 0) begin
          e = sb2.pop_front();
          check("res2", res2, e[7:0]);
          check("ovf2", ovf2, e[8]);
          check("busy2_cycles", bc2, 2);
        end
        bc2 = 0;
      end
      if (rv3 && !rv3_p) begin
        check("sb3_pending", 32'(sb3.size() > 0), 1);
        if (sb3.size() > 0) begin
          e = sb3.pop_front();
          check("res3", res3, e[7:0]);
          check("ovf3", ovf3, e[8]);
          check("busy3_cycles", bc3, 3);
        end
        bc3 = 0;
      end
    end
    rv2_p = rv2;
    rv3_p = rv3;
  end

  task automatic op(input bit s3, input logic [7:0] v);
    if (s3) begin din3 = v; go3 = 1'b1; end
    else    begin din2 = v; go2 = 1'b1; end
    @(posedge clk); #1;
    go2 = 1'b0;
    go3 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push(input bit s3, input int c[5]);
    if (s3) sb3.push_back(model(3, c));
    else    sb2.push_back(model(2, c));
  endtask

  task automatic eval(input bit s3, input int c[5]);
    int n;
    n = s3 ? 3 : 2;
    for (int k = 0; k <= n; k++) op(s3, 8'(c[k]));
    push(s3, c);
    op(s3, 8'(c[n+1]));
  endtask

  task automatic wait_rv(input bit s3);
    for (int i = 0; i < 40; i++) begin
      if (s3 ? rv3 : rv2) break;
      @(posedge clk); #1;
    end
    check("rv_timeout", s3 ? rv3 : rv2, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb2.delete();
    sb3.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    go2 = 1'b0; go3 = 1'b0;
    din2 = '0;  din3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res", res2, 0);
    check("rst_rv", rv2, 0);
    check("rst_ovf", ovf2, 0);
    check("rst_busy", busy2, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 2x^2+3x+4 at 5
    eval(0, '{2, 3, 4, 5, 0});
    check("t1_busy", busy2, 1);
    @(posedge clk); #1;
    check("t1_rv_early", rv2, 0);
    @(posedge clk); #1;
    check("t1_rv", rv2, 1);
    check("t1_res", res2, 69);
    check("t1_ovf", ovf2, 0);
    check("t1_busy_off", busy2, 0);

    // Overflow case, then overflow must clear at a_N capture
    eval(0, '{2, 3, 4, 20, 0});
    wait_rv(0);
    check("t2_res", res2, 96);
    check("t2_ovf", ovf2, 1);
    op(0, 8'd1);
    check("t2_ovf_clr", ovf2, 0);
    check("t2_rv_clr", rv2, 0);
    check("t2_res_hold", res2, 96);
    op(0, 8'd0);
    op(0, 8'd0);
    push(0, '{1, 0, 0, 3, 0});
    op(0, 8'd3);
    wait_rv(0);
    check("t3_res", res2, 9);
    check("t3_ovf", ovf2, 0);

    // DEGREE=3: x^3+1 at 3, exactly 3 compute cycles
    eval(1, '{1, 0, 0, 1, 3});
    repeat (2) begin @(posedge clk); #1; end
    check("t4_rv_early", rv3, 0);
    @(posedge clk); #1;
    check("t4_rv", rv3, 1);
    check("t4_res", res3, 28);

    // Reset on the first COMPUTE cycle
    eval(0, '{2, 3, 4, 5, 0});
    check("t5_busy", busy2, 1);
    do_reset();
    check("t5_res", res2, 0);
    check("t5_rv", rv2, 0);
    check("t5_ovf", ovf2, 0);
    check("t5_busy0", busy2, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_no_result", rv2, 0);
    eval(0, '{1, 1, 1, 2, 0});
    wait_rv(0);
    check("t5_res7", res2, 7);

    // Go pressed and held during COMPUTE
    eval(0, '{1, 2, 3, 4, 0});
    go2  = 1'b1;
    din2 = 8'd99;
    repeat (5) begin @(posedge clk); #1; end
    go2 = 1'b0;
    @(posedge clk); #1;
    check("t6_rv_hold", rv2, 1);
    check("t6_res", res2, 27);
    @(posedge clk); #1;
    check("t6_rv_idle", rv2, 1);
    op(0, 8'd5);
    check("t6_rv_drop", rv2, 0);
    check("t6_res_hold", res2, 27);
    op(0, 8'd0);
    op(0, 8'd0);
    push(0, '{5, 0, 0, 1, 0});
    op(0, 8'd1);
    wait_rv(0);
    check("t6_res5", res2, 5);

    // Go held 10 cycles on a_N while DataIn changes
    din2 = 8'd3;
    go2  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      din2 = 8'(100 + i);
    end
    go2 = 1'b0;
    @(posedge clk); #1;
    op(0, 8'd0);
    op(0, 8'd0);
    push(0, '{3, 0, 0, 2, 0});
    op(0, 8'd2);
    wait_rv(0);
    check("t7_res", res2, 12);

    repeat (2) @(posedge clk);
    #1;
    check("sb2_drain", sb2.size(), 0);
    check("sb3_drain", sb3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/poly_eval_horner.md
# poly_eval_horner

Parametrised polynomial evaluator: p(x) = a_N·x^N + … + a_1·x + a_0, N = DEGREE, computed by Horner's rule on a single multiply-accumulate datapath. It is the generalised successor of the fixed three-coefficient quadratic evaluator. Operands enter one per Go press/release through the same switch-and-button style handshake, and the result is held on a registered output with a valid flag. It adds an overflow flag and a busy indicator.

## Interface
- WIDTH, 8: bit width of coefficients, x, accumulator and result.
- DEGREE, 2: polynomial degree N, legal range 1..15. The block stores N+1 coefficients.
- Clock  in  1  system clock; all state changes on its rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- Go  in  1  operand strobe; an operand is captured on press and the block advances on release.
- DataIn  in  WIDTH  operand value: a coefficient or x.
- DataResult  out  WIDTH  p(x) mod 2^WIDTH; registered.
- ResultValid  out  1  DataResult holds a completed evaluation.
- Overflow  out  1  some intermediate of the last evaluation exceeded 2^WIDTH−1.
- Busy  out  1  high while computing.

## Operation
- States: LOAD, LOAD_WAIT, COMPUTE, RELEASE_WAIT.
- Operand index idx counts down from DEGREE+1 to 0:
  - idx = DEGREE+1 selects a_N.
  - idx = DEGREE−k+1 selects a_(N−k).
  - idx = 1 selects a_0.
  - idx = 0 selects x.
- Entry order is therefore a_N first, a_0 second to last, x last.
- LOAD:
  - On an edge with Go=1, capture DataIn into the slot selected by idx and go to LOAD_WAIT.
  - With Go=0, stay in LOAD.
- Capture of a_N additionally clears ResultValid and Overflow.
- LOAD_WAIT:
  - Stay while Go=1.
  - On Go=0 with idx>0: decrement idx and return to LOAD.
  - On Go=0 with idx=0: go to COMPUTE, set acc ← a_N and step counter s ← DEGREE−1.
- COMPUTE: each edge does acc ← (acc·x + a_s) mod 2^WIDTH, then s ← s−1.
  - Full-precision product and sum are formed at 2·WIDTH+1 bits.
  - If that value is ≥ 2^WIDTH, Overflow is set (sticky).
  - On the edge with s=0:
    - DataResult ← new acc and ResultValid ← 1.
    - idx ← DEGREE+1.
    - Next state is RELEASE_WAIT if Go=1, else LOAD.
- RELEASE_WAIT: stay while Go=1; go to LOAD on Go=0. This prevents a Go pressed during COMPUTE from capturing a_N.
- Go is ignored in COMPUTE.
- ResultValid and DataResult hold through the next load sequence until a_N is captured. At that capture DataResult holds its value and only ResultValid drops.
- Busy = 1 exactly in COMPUTE.
- Arithmetic is unsigned with truncation to WIDTH; coefficients are unsigned.

## Timing
- Reset (Resetn=0 at an edge), taking effect that edge from any state including mid-COMPUTE:
  - state = LOAD, idx = DEGREE+1.
  - All coefficient registers, x and acc = 0.
  - DataResult = 0, ResultValid = 0, Overflow = 0, Busy = 0.
- A reset during COMPUTE aborts the evaluation; no partial result appears.
- Capture edge: the first edge in LOAD where Go=1. Later DataIn changes while Go is held have no effect.
- Minimum operand cost is 2 cycles (press edge, release edge), so DEGREE+2 operands take ≥ 2·(DEGREE+2) cycles.
- Latency: COMPUTE is entered on the edge where x's release is seen. ResultValid rises DEGREE edges later; Busy is high for exactly DEGREE cycles.
- Overflow is valid alongside ResultValid and updates only in COMPUTE.
- Go asserted on the same edge COMPUTE finishes leads to RELEASE_WAIT; no capture occurs.
- Back-to-back evaluations need no idle cycle beyond the Go release.

## Test plan
- DEGREE=2, WIDTH=8; enter a2=2, a1=3, a0=4, x=5 → after 2 COMPUTE cycles: DataResult=69, ResultValid=1, Overflow=0, Busy high for 2 cycles.
- Same block; enter 2, 3, 4, x=20 → DataResult=96 (864 mod 256), Overflow=1. Next run 1, 0, 0, x=3 → Overflow=0 and DataResult=9. Overflow must drop at the a_N capture.
- DEGREE=3; enter a3=1, a2=0, a1=0, a0=1, x=3 → DataResult=28 after exactly 3 COMPUTE cycles.
- Reset mid-operation:
  - DEGREE=2; enter 2, 3, 4, 5.
  - Pull Resetn low for one edge on the first COMPUTE cycle.
  - Required: all outputs 0 and state LOAD.
  - Then enter 1, 1, 1, x=2 → DataResult=7.
- Go pressed during COMPUTE and held 5 cycles with DataIn=99 → no capture. After release, the next press captures a_N normally, and the prior result stays valid until that press.
- Go held high for 10 cycles on a coefficient while DataIn changes each cycle → only the value present on the first Go=1 edge is stored.
